// File: rtl/gravsim_util_pkg.sv
// gravsim_util_pkg: shared stage record, depth limits and delay clamp for the programmable delay line
package gravsim_util_pkg;
  localparam int DL_MIN_DEPTH = 2;
  localparam int DL_MAX_DEPTH = 256;
  localparam int DL_WORD_W = 32;
  localparam int DL_LANES = 3;
  typedef struct packed {
    logic valid;
    logic [DL_LANES-1:0][DL_WORD_W-1:0] data;
  } dl_stage_t;
  function automatic int unsigned dl_clamp(input int unsigned cfg, input int unsigned depth);
    return cfg == 0 ? 1 : (cfg > depth ? depth : cfg);
  endfunction
endpackage

// File: rtl/dl_tap_mux.sv
// dl_tap_mux: selects stage d_eff-1 and zeroes the data word when that stage is empty
module dl_tap_mux #(
  parameter int DEPTH = 16,
  parameter int W = 96,
  parameter int DW = 5
) (
  input  logic [DEPTH-1:0] vld,
  input  logic [W-1:0]     dat [DEPTH],
  input  logic [DW-1:0]    d_eff,
  output logic             out_valid,
  output logic [W-1:0]     out_data
);
  localparam int SW = $clog2(DEPTH);
  logic [SW-1:0] sel;
  always_comb begin
    sel = SW'(d_eff - DW'(1));
    out_valid = vld[sel];
    out_data = out_valid ? dat[sel] : '0;
  end
endmodule

// File: rtl/prog_delay_line.sv
// prog_delay_line: multi-lane delay line with runtime-selectable tap and sticky config error
// Optional occupancy counter compiled in with PROG_DELAY_LINE_OCC_EN.
module prog_delay_line
  import gravsim_util_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS = 3,
  parameter int MAX_DEPTH = 16,
  localparam int DW_CFG = $clog2(MAX_DEPTH + 1),
  localparam int W = CHANNELS * DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic [DW_CFG-1:0] delay_cfg,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic              cfg_err,
  output logic [DW_CFG-1:0] occupancy
);
  localparam logic [DW_CFG-1:0] MAX_D = DW_CFG'(MAX_DEPTH);
  logic [MAX_DEPTH-1:0] vld;
  logic [W-1:0] dat [MAX_DEPTH];
  logic [DW_CFG-1:0] d_eff;
  logic cfg_bad;
  always_comb begin
    d_eff = DW_CFG'(dl_clamp(32'(delay_cfg), MAX_DEPTH));
    cfg_bad = delay_cfg == '0 || delay_cfg > MAX_D;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld <= '0;
    else if (flush) vld <= '0;
    else if (en) vld <= {vld[MAX_DEPTH-2:0], in_valid};
  // data words are never reset; empty stages are masked at the tap
  always_ff @(posedge clk)
    if (en && !flush) begin
      dat[0] <= in_data;
      for (int i = 1; i < MAX_DEPTH; i++) dat[i] <= dat[i-1];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cfg_err <= 1'b0;
    else if (cfg_bad) cfg_err <= 1'b1;
    else if (flush) cfg_err <= 1'b0;
`ifdef PROG_DELAY_LINE_OCC_EN
  logic [DW_CFG-1:0] occ;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) occ <= '0;
    else if (flush) occ <= '0;
    else if (en) occ <= occ + DW_CFG'(in_valid) - DW_CFG'(vld[MAX_DEPTH-1]);
  assign occupancy = occ;
`else
  assign occupancy = '0;
`endif
  dl_tap_mux #(.DEPTH(MAX_DEPTH), .W(W), .DW(DW_CFG)) u_tap (
    .vld(vld),
    .dat(dat),
    .d_eff(d_eff),
    .out_valid(out_valid),
    .out_data(out_data)
  );
endmodule

// File: tb/tb_prog_delay_line.sv
// tb_prog_delay_line: directed and random stimulus against a history-list reference model
module tb_prog_delay_line;
  localparam int DEPTH = 16;
  localparam int W = 96;
  localparam int DWC = 5;
  logic clk = 0;
  logic rst_n, en, flush, in_valid, out_valid, cfg_err;
  logic [DWC-1:0] delay_cfg, occupancy;
  logic [W-1:0] in_data, out_data;
  int total = 0, bad = 0;
  typedef struct {logic v; logic [W-1:0] d;} smp_t;
  smp_t hist[$];
  logic m_err;
  always #5 clk = ~clk;
  prog_delay_line #(.DATA_WIDTH(32), .CHANNELS(3), .MAX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .delay_cfg(delay_cfg),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
    .out_data(out_data), .cfg_err(cfg_err), .occupancy(occupancy)
  );
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int eff(input int c);
    return c == 0 ? 1 : (c > DEPTH ? DEPTH : c);
  endfunction
  task automatic check_outputs(input string tag);
    int k;
    int n;
    logic ev;
    logic [W-1:0] ed;
    k = eff(int'(delay_cfg)) - 1;
    ev = k < hist.size() ? hist[k].v : 1'b0;
    ed = ev ? hist[k].d : '0;
    n = 0;
    foreach (hist[i]) n += int'(hist[i].v);
    check({tag, ".vld"}, W'(out_valid), W'(ev));
    check({tag, ".dat"}, out_data, ed);
    check({tag, ".err"}, W'(cfg_err), W'(m_err));
`ifdef PROG_DELAY_LINE_OCC_EN
    check({tag, ".occ"}, W'(occupancy), W'(n));
`else
    check({tag, ".occ"}, W'(occupancy), W'(0));
`endif
  endtask
  task automatic step(input string tag, input logic e, input logic f, input logic v,
                      input logic [W-1:0] d, input int c);
    en = e; flush = f; in_valid = v; in_data = d; delay_cfg = DWC'(c);
    @(posedge clk);
    if (c == 0 || c > DEPTH) m_err = 1'b1;
    else if (f) m_err = 1'b0;
    if (f) foreach (hist[i]) hist[i].v = 1'b0;
    else if (e) begin
      hist.push_front('{v, d});
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    #1 check_outputs(tag);
  endtask
  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom};
  endfunction
  initial begin
    logic [W-1:0] smp [8];
    logic [W-1:0] held;
    int c;
    rst_n = 0; en = 0; flush = 0; in_valid = 0; in_data = '0; delay_cfg = 5; m_err = 0;
    repeat (2) @(posedge clk);
    #1 check_outputs("reset");
    @(negedge clk) rst_n = 1;
    foreach (smp[i]) smp[i] = rnd();
    for (int i = 0; i < 8; i++) step("seq5", 1, 0, 1, smp[i], 5);
    for (int i = 0; i < 12; i++) step("seq5_tail", 1, 0, 0, rnd(), 5);
    step("flush_clr", 1, 1, 0, '0, 5);
    for (int i = 0; i < 5; i++) step("stall_pre", 1, 0, 1, rnd(), 3);
    held = out_data;
    for (int i = 0; i < 4; i++) begin
      step("stall", 0, 0, 1, rnd(), 3);
      check("stall_frozen", out_data, held);
    end
    for (int i = 0; i < 6; i++) step("stall_post", 1, 0, 0, rnd(), 3);
    for (int i = 0; i < 3; i++) step("fl_pre", 1, 0, 1, rnd(), 2);
    step("flush_en", 1, 1, 1, rnd(), 2);
    check("flush_ov", W'(out_valid), W'(0));
    for (int i = 0; i < 4; i++) step("fl_post", 1, 0, 0, rnd(), 2);
    for (int i = 0; i < 3; i++) step("cfg0", 1, 0, 1, rnd(), 0);
    for (int i = 0; i < 20; i++) step("cfg20", 1, 0, i < 3, rnd(), 20);
    for (int i = 0; i < 3; i++) step("err_sticky", 1, 0, 0, rnd(), 4);
    check("err_held", W'(cfg_err), W'(1));
    step("err_flush", 1, 1, 0, '0, 4);
    check("err_cleared", W'(cfg_err), W'(0));
    for (int i = 0; i < 6; i++) step("ar_pre", 1, 0, 1, rnd(), 2);
    #3 rst_n = 0;
    hist.delete(); m_err = 0;
    #1 check_outputs("async_rst");
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 4; i++) step("ar_post", 1, 0, 0, rnd(), 2);
    c = 5;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) c = $urandom_range(0, 20);
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1, rnd(), c);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
